// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the seven-segment display sequencer.
package hex_disp_pkg;
  localparam int DIGIT_W    = 3;
  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_BLANK_AL = 7'h7F;
  localparam logic [6:0] SEG_BLANK_AH = 7'h00;

  // Active-high glyphs, bit0 = seg a .. bit6 = seg g; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_REFRESH} state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    logic       blank;
    logic [3:0] value;
  } shadow_t;

  typedef struct packed {
    digit_t     digit;
    logic [3:0] value;
    logic       blank;
  } req_t;
endpackage

// File: rtl/hex_disp_ctrl_if.sv
// Client request ports plus the Avalon-style PIO write bus.
interface hex_disp_ctrl_if #(parameter int NUM_DIGITS = 4);
  import hex_disp_pkg::*;

  logic                  rq0_valid;
  digit_t                rq0_digit;
  logic [3:0]            rq0_value;
  logic                  rq0_blank;
  logic                  rq0_ready;
  logic                  rq1_valid;
  digit_t                rq1_digit;
  logic [3:0]            rq1_value;
  logic                  rq1_blank;
  logic                  rq1_ready;
  logic [NUM_DIGITS-1:0] hex_chipselect;
  logic [1:0]            hex_address;
  logic                  hex_write_n;
  logic [6:0]            hex_writedata;

  // Requester / bus-observer side.
  modport master (
    output rq0_valid, rq0_digit, rq0_value, rq0_blank,
    output rq1_valid, rq1_digit, rq1_value, rq1_blank,
    input  rq0_ready, rq1_ready,
    input  hex_chipselect, hex_address, hex_write_n, hex_writedata
  );

  // Controller side.
  modport slave (
    input  rq0_valid, rq0_digit, rq0_value, rq0_blank,
    input  rq1_valid, rq1_digit, rq1_value, rq1_blank,
    output rq0_ready, rq1_ready,
    output hex_chipselect, hex_address, hex_write_n, hex_writedata
  );
endinterface

// File: rtl/hex_seg_enc.sv
// Nibble + blank flag to seven-segment pattern, selectable polarity.
module hex_seg_enc
  import hex_disp_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup, inverted for common-anode displays.
  always_comb begin
    if (blank) seg = ACTIVE_LOW ? SEG_BLANK_AL : SEG_BLANK_AH;
    else       seg = ACTIVE_LOW ? ~GLYPH[value] : GLYPH[value];
  end

endmodule

// File: rtl/hex_disp_ctrl.sv
// Round-robin update arbiter, digit shadow store and PIO write sequencer.
module hex_disp_ctrl
  import hex_disp_pkg::*;
#(
  parameter int          NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_CYCLES = 50000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  hex_disp_ctrl_if.slave  bus,
  output logic            busy
);

  state_t                state, state_nxt;
  digit_t                idx, idx_nxt, tgt_idx;
  logic                  last_grant;
  shadow_t               shadow [MAX_DIGITS];
  logic                  pending, tick, done;
  logic [31:0]           rcnt;
  logic                  grant0, grant1, accept, in_range;
  req_t                  req;
  logic [3:0]            enc_value;
  logic                  enc_blank;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] cs_q, cs_nxt;
  logic                  wn_q, wn_nxt;
  logic [6:0]            wd_q, wd_nxt;

  // Grant in IDLE only, priority rotates away from the last winner; also picks what to encode.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n && state == ST_IDLE) begin
      grant0 = bus.rq0_valid & (~bus.rq1_valid | last_grant);
      grant1 = bus.rq1_valid & (~bus.rq0_valid | ~last_grant);
    end
    accept = grant0 | grant1;
    if (grant1) req = '{digit: bus.rq1_digit, value: bus.rq1_value, blank: bus.rq1_blank};
    else        req = '{digit: bus.rq0_digit, value: bus.rq0_value, blank: bus.rq0_blank};
    // Refresh always encodes the digit it is about to present next cycle.
    tgt_idx   = (state == ST_IDLE) ? '0 : idx + 1'b1;
    enc_value = accept ? req.value : shadow[tgt_idx].value;
    enc_blank = accept ? req.blank : shadow[tgt_idx].blank;
  end

  assign in_range = {1'b0, req.digit} < 4'(NUM_DIGITS);

  hex_seg_enc #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_enc (
    .value (enc_value),
    .blank (enc_blank),
    .seg   (seg)
  );

  // Next state and next registered bus word; the bus shows the write during WRITE/REFRESH.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    done      = 1'b0;
    cs_nxt    = '0;
    wn_nxt    = 1'b1;
    wd_nxt    = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_WRITE;
          if (in_range) begin
            cs_nxt = NUM_DIGITS'(1) << req.digit;
            wn_nxt = 1'b0;
            wd_nxt = seg;
          end
        end else if (pending) begin
          state_nxt = ST_REFRESH;
          idx_nxt   = '0;
          cs_nxt    = NUM_DIGITS'(1);
          wn_nxt    = 1'b0;
          wd_nxt    = seg;
        end
      end
      ST_WRITE: state_nxt = ST_IDLE;
      ST_REFRESH: begin
        if (idx == digit_t'(NUM_DIGITS - 1)) begin
          state_nxt = ST_IDLE;
          done      = 1'b1;
        end else begin
          idx_nxt = tgt_idx;
          cs_nxt  = NUM_DIGITS'(1) << tgt_idx;
          wn_nxt  = 1'b0;
          wd_nxt  = seg;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tick = (REFRESH_CYCLES != 0) && (rcnt == REFRESH_CYCLES - 1);

  // State, shadows, refresh timer and registered bus outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      last_grant <= 1'b1;
      pending    <= 1'b1;
      rcnt       <= '0;
      cs_q       <= '0;
      wn_q       <= 1'b1;
      wd_q       <= '0;
      for (int i = 0; i < MAX_DIGITS; i++) shadow[i] <= '{blank: 1'b1, value: 4'h0};
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cs_q  <= cs_nxt;
      wn_q  <= wn_nxt;
      wd_q  <= wd_nxt;
      if (accept) begin
        last_grant <= grant1;
        if (in_range) shadow[req.digit] <= '{blank: req.blank, value: req.value};
      end
      if (REFRESH_CYCLES == 0 || tick) rcnt <= '0;
      else                             rcnt <= rcnt + 32'd1;
      // A wrap on the final refresh edge re-arms rather than being lost.
      pending <= tick | (pending & ~done);
    end
  end

  assign bus.rq0_ready      = grant0;
  assign bus.rq1_ready      = grant1;
  assign bus.hex_chipselect = cs_q;
  assign bus.hex_address    = 2'b00;
  assign bus.hex_write_n    = wn_q;
  assign bus.hex_writedata  = wd_q;
  assign busy               = state != ST_IDLE;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Directed + randomized bench for hex_disp_ctrl with a slot-queue reference model.
module tb_hex_disp_ctrl;
  localparam int NUMD = 4;
  localparam int RC   = 20;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_chk = 0;
  int   n_fail = 0;

  hex_disp_ctrl_if #(.NUM_DIGITS(NUMD)) bus ();

  hex_disp_ctrl #(.NUM_DIGITS(NUMD), .REFRESH_CYCLES(RC), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus.slave),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low hex glyphs 0..F.
  logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [3:0] cs;
    logic       wn;
    logic [6:0] wd;
    logic       last;
  } slot_t;

  // Model: q holds the bus word for each upcoming busy cycle; empty queue = idle.
  slot_t q[$];
  bit    m_init = 1'b0;
  bit    m_last, m_pend;
  int    m_cnt;
  bit    m_blank [8];
  int    m_val [8];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int pick(bit v0, bit v1, bit last);
    if (v0 && (!v1 || last)) return 1;
    if (v1 && (!v0 || !last)) return 2;
    return 0;
  endfunction

  function automatic logic [6:0] pattern(bit b, int v);
    return b ? 7'h7F : GL[v];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_last = 1'b1;
      m_pend = 1'b1;
      m_cnt  = 0;
      for (int i = 0; i < 8; i++) begin m_blank[i] = 1'b1; m_val[i] = 0; end
      m_init = 1'b1;
    end else if (m_init) begin
      bit    done, b, tk;
      int    g, d, v;
      slot_t s;
      done = 1'b0;
      if (q.size() == 0) begin
        g = pick(bus.rq0_valid, bus.rq1_valid, m_last);
        if (g != 0) begin
          d = (g == 1) ? int'(bus.rq0_digit) : int'(bus.rq1_digit);
          v = (g == 1) ? int'(bus.rq0_value) : int'(bus.rq1_value);
          b = (g == 1) ? bus.rq0_blank : bus.rq1_blank;
          m_last = (g == 2);
          s = '0;
          if (d < NUMD) begin
            m_blank[d] = b;
            m_val[d]   = v;
            s.cs = 4'b0001 << d;
            s.wd = pattern(b, v);
          end else s.wn = 1'b1;
          q.push_back(s);
        end else if (m_pend) begin
          for (int i = 0; i < NUMD; i++) begin
            s      = '0;
            s.cs   = 4'b0001 << i;
            s.wd   = pattern(m_blank[i], m_val[i]);
            s.last = (i == NUMD - 1);
            q.push_back(s);
          end
        end
      end else begin
        done = q[0].last;
        void'(q.pop_front());
      end
      tk     = (m_cnt == RC - 1);
      m_cnt  = tk ? 0 : m_cnt + 1;
      m_pend = tk || (m_pend && !done);
    end
  end

  // Every cycle: compare the DUT against the model's current slot and grant.
  always @(negedge clk) begin
    if (m_init) begin
      int g;
      bit idle;
      idle = (q.size() == 0);
      g = (!rst_n || !idle) ? 0 : pick(bus.rq0_valid, bus.rq1_valid, m_last);
      chk("ready0", bus.rq0_ready, g == 1);
      chk("ready1", bus.rq1_ready, g == 2);
      chk("busy", busy, !idle);
      chk("address", bus.hex_address, 0);
      if (idle) begin
        chk("cs_idle", bus.hex_chipselect, 0);
        chk("wn_idle", bus.hex_write_n, 1);
      end else begin
        chk("cs", bus.hex_chipselect, q[0].cs);
        chk("wn", bus.hex_write_n, q[0].wn);
        if (!q[0].wn) chk("wd", bus.hex_writedata, q[0].wd);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(int v, int d, int val, int b);
    bus.rq0_valid = v[0]; bus.rq0_digit = 3'(d); bus.rq0_value = 4'(val); bus.rq0_blank = b[0];
  endtask

  task automatic drv1(int v, int d, int val, int b);
    bus.rq1_valid = v[0]; bus.rq1_digit = 3'(d); bus.rq1_value = 4'(val); bus.rq1_blank = b[0];
  endtask

  task automatic wr(string nm, logic [3:0] cs, logic [6:0] wd);
    chk({nm, "_cs"}, bus.hex_chipselect, cs);
    chk({nm, "_wn"}, bus.hex_write_n, 0);
    chk({nm, "_wd"}, bus.hex_writedata, wd);
  endtask

  initial begin
    rst_n = 1'b0;
    drv0(1, 2, 5, 0);
    drv1(0, 0, 0, 0);
    step; step;
    chk("rst_cs", bus.hex_chipselect, 0);
    chk("rst_wn", bus.hex_write_n, 1);
    chk("rst_wd", bus.hex_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", bus.rq0_ready, 0);
    drv0(0, 0, 0, 0);
    step;
    rst_n = 1'b1;
    // Power-up refresh paints every digit blank.
    step; wr("pu0", 4'b0001, 7'h7F);
    step; wr("pu1", 4'b0010, 7'h7F);
    step; wr("pu2", 4'b0100, 7'h7F);
    step; wr("pu3", 4'b1000, 7'h7F);
    step; chk("pu_done_busy", busy, 0); chk("pu_done_wn", bus.hex_write_n, 1);
    // Single update, digit 2 = 5.
    drv0(1, 2, 5, 0); #1;
    chk("t2_ready0", bus.rq0_ready, 1);
    step; chk("t2_ready_in_write", bus.rq0_ready, 0); drv0(0, 0, 0, 0);
    wr("t2", 4'b0100, 7'h12);
    step;
    // Out-of-range digit from rq1.
    drv1(1, 6, 9, 0); #1;
    chk("t5_ready1", bus.rq1_ready, 1);
    chk("t5_ready0", bus.rq0_ready, 0);
    step; drv1(0, 0, 0, 0);
    chk("t5_cs", bus.hex_chipselect, 0);
    chk("t5_wn", bus.hex_write_n, 1);
    chk("t5_busy", busy, 1);
    step;
    // Both held: rq0, rq1, rq0, two cycles apart.
    drv0(1, 0, 1, 0); drv1(1, 1, 3, 0); #1;
    chk("t3_r0_first", bus.rq0_ready, 1);
    chk("t3_r1_first", bus.rq1_ready, 0);
    step; wr("t3_w0", 4'b0001, 7'h79);
    chk("t3_r1_busy", bus.rq1_ready, 0);
    step; chk("t3_gap_wn", bus.hex_write_n, 1);
    chk("t3_r1_second", bus.rq1_ready, 1);
    chk("t3_r0_second", bus.rq0_ready, 0);
    step; wr("t3_w1", 4'b0010, 7'h30);
    step; chk("t3_r0_third", bus.rq0_ready, 1);
    step; wr("t3_w2", 4'b0001, 7'h79);
    drv0(0, 0, 0, 0); drv1(0, 0, 0, 0);
    step;
    // Digit 3 = A, then the periodic refresh after the wrap.
    drv0(1, 3, 10, 0);
    step; drv0(0, 0, 0, 0); wr("t4_wa", 4'b1000, 7'h08);
    repeat (5) step;
    wr("t4_r0", 4'b0001, 7'h79);
    step; wr("t4_r1", 4'b0010, 7'h30);
    drv1(1, 2, 0, 0); #1;
    chk("t4_wait1", bus.rq1_ready, 0);
    step; wr("t4_r2", 4'b0100, 7'h12); chk("t4_wait2", bus.rq1_ready, 0);
    step; wr("t4_r3", 4'b1000, 7'h08); chk("t4_wait3", bus.rq1_ready, 0);
    step; chk("t4_after_wn", bus.hex_write_n, 1); chk("t4_after_busy", busy, 0);
    chk("t4_accept", bus.rq1_ready, 1);
    step; drv1(0, 0, 0, 0); wr("t4_late", 4'b0100, 7'h40);
    // Reset during refresh idx 1 aborts, then a blank refresh follows.
    repeat (16) step;
    wr("t6_r1", 4'b0010, 7'h30);
    rst_n = 1'b0;
    step;
    chk("t6_abort_cs", bus.hex_chipselect, 0);
    chk("t6_abort_wn", bus.hex_write_n, 1);
    chk("t6_abort_busy", busy, 0);
    rst_n = 1'b1;
    step; wr("t6_b0", 4'b0001, 7'h7F);
    step; wr("t6_b1", 4'b0010, 7'h7F);
    step; wr("t6_b2", 4'b0100, 7'h7F);
    step; wr("t6_b3", 4'b1000, 7'h7F);
    // Random traffic, occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0)
        drv0(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0)
        drv1(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 7) == 0));
      step;
    end
    rst_n = 1'b1;
    drv0(0, 0, 0, 0);
    drv1(0, 0, 0, 0);
    repeat (10) step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
